// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for signed or unsigned WIDTH-bit operands.
// The datapath works on magnitudes, one quotient bit per cycle, and then applies a
// one-cycle sign fix-up. It uses a start/in_ready handshake on the input side and an
// out_valid/out_ready handshake on the output side.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,      // active-high, asynchronous
    input  logic             start,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] q_reg;      // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] d_reg;      // divisor magnitude
    logic [WIDTH-1:0] r_reg;      // partial remainder; always < d_reg between steps
    logic [CW-1:0]    count;
    logic             neg_q, neg_r;

    // Operand signs and magnitudes. abs(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is the
    // correct unsigned magnitude.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             accept;

    assign a_neg  = is_signed & dividend[WIDTH-1];
    assign b_neg  = is_signed & divisor[WIDTH-1];
    assign a_mag  = a_neg ? -dividend : dividend;
    assign b_mag  = b_neg ? -divisor  : divisor;
    assign accept = start && (state == IDLE);

    // One restoring step. The shifted remainder needs WIDTH+1 bits, but the difference
    // is always below the divisor, so its low WIDTH bits are exact.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_sub;
    logic             step_ge;

    assign r_shift = {r_reg, q_reg[WIDTH-1]};
    assign step_ge = r_shift >= {1'b0, d_reg};
    assign r_sub   = r_shift[WIDTH-1:0] - d_reg;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of the order of the statements.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start)         state_next = (divisor == '0) ? DONE : CALC;
            CALC: if (count == '0)   state_next = FIX;
            FIX:                     state_next = DONE;
            DONE: if (out_ready)     state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Datapath and result registers.
    // NOTE: every register, including the result outputs, is cleared by reset, so an
    // aborted operation leaves no residue.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            q_reg       <= '0;
            d_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        q_reg <= a_mag;
                        d_reg <= b_mag;
                        r_reg <= '0;
                        count <= CW'(WIDTH - 1);
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_reg <= step_ge ? r_sub : r_shift[WIDTH-1:0];
                    q_reg <= {q_reg[WIDTH-2:0], step_ge};
                    if (count != '0) count <= count - CW'(1);
                end
                FIX: begin
                    quotient    <= neg_q ? -q_reg : q_reg;
                    remainder   <= neg_r ? -r_reg : r_reg;
                    div_by_zero <= 1'b0;
                end
                default: ;  // DONE: hold results until the consumer takes them
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle radix-2 integer divider: the inverse operation to the team's combinational Booth/Wallace multiplier.
- Sits beside the multiplier in the execute stage and produces quotient and remainder for signed or unsigned WIDTH-bit operands.
- Uses a start/ready input handshake and a valid/ready output handshake, so the pipeline can stall on it.
- One iteration per cycle; shift-subtract datapath on magnitudes with a final sign fix-up.

Parameters:
WIDTH, 32, operand/result width in bits (even, >= 4)

Ports:
clk  input  1  clock, rising edge
resetn  input  1  asynchronous, active-high reset: resetn=1 clears all state immediately
start  input  1  request; accepted when start && in_ready
in_ready  output  1  high only in IDLE
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept
dividend  input  WIDTH  numerator; sampled at accept
divisor  input  WIDTH  denominator; sampled at accept
out_valid  output  1  result valid; held until out_ready
out_ready  input  1  consumer accepts result when out_valid && out_ready
quotient  output  WIDTH  quotient, truncated toward zero
remainder  output  WIDTH  remainder; sign follows the dividend
div_by_zero  output  1  result was produced with divisor == 0; valid with out_valid

Behaviour:
- Reset (resetn=1, any cycle, including mid-operation):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal registers and counter are cleared; any in-flight operation is discarded.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On accept, latch the operands, is_signed, neg_q = signed && (sign(dividend) ^ sign(divisor)), and neg_r = signed && sign(dividend).
  - Load magnitudes: abs() when signed, raw otherwise. Clear the partial remainder and set count=WIDTH-1.
  - If divisor==0, go to DONE directly with quotient=all ones, remainder=dividend as given, div_by_zero=1.
  - Otherwise go to CALC.
- CALC: one restoring step per cycle.
  - r' = {r[WIDTH-1:0], q[WIDTH-1]}; q shifts left.
  - If r' >= |divisor|, then r = r' - |divisor| and the new q LSB = 1; else r = r' and LSB = 0.
  - r is WIDTH+1 bits wide to avoid overflow.
  - When count==0, go to FIX; else count decrements. CALC lasts exactly WIDTH cycles.
- FIX (1 cycle):
  - quotient = neg_q ? -q : q.
  - remainder = neg_r ? -r : r, truncated to WIDTH bits.
  - div_by_zero=0. Go to DONE.
- DONE:
  - out_valid=1; outputs are stable while out_valid && !out_ready.
  - On out_ready, go to IDLE and drop out_valid the next cycle.
  - start is ignored (in_ready=0) until IDLE.
- Latency from the accept edge to out_valid=1:
  - WIDTH+2 cycles for a nonzero divisor (34 at default).
  - 1 cycle for divisor==0.
- Signed overflow: -2^(WIDTH-1) / -1 gives quotient=-2^(WIDTH-1) (0x80000000) and remainder=0. This falls out of the magnitude arithmetic modulo 2^WIDTH; no special case is needed.
- abs(-2^(WIDTH-1)) is treated as unsigned 2^(WIDTH-1), which is correct in the unsigned magnitude datapath.
- Back-to-back operation: at the earliest, the next accept happens in the cycle after the DONE handshake. There is no same-cycle DONE->accept.
- Changes on dividend, divisor, or is_signed outside the accept cycle have no effect.
- Fully synchronous to clk apart from the async reset. No combinational path from inputs to outputs, except that in_ready depends on state only.

Test Plan:
- Unsigned: is_signed=0, 100 / 7 -> after 34 cycles out_valid=1, quotient=14, remainder=2, div_by_zero=0. Also 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- Signed sign combinations:
  - -7 / 2 -> quotient=-3 (0xFFFFFFFD), remainder=-1.
  - 7 / -2 -> quotient=-3, remainder=1.
  - -7 / -2 -> quotient=3, remainder=-1.
- Corner cases:
  - 0x80000000 / 0xFFFFFFFF signed -> quotient=0x80000000, remainder=0.
  - 5 / 9 -> quotient=0, remainder=5.
  - 0 / 3 -> quotient=0, remainder=0.
- Divide by zero: dividend=0x1234, divisor=0 (signed and unsigned) -> out_valid 1 cycle after accept, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Handshake:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs are stable and in_ready=0.
  - Assert start during CALC -> ignored.
  - Raise out_ready -> in_ready=1 the next cycle; a new op is accepted then.
- Reset mid-operation: assert resetn=1 for 2 cycles at CALC cycle 15 -> outputs go to 0 and in_ready=1 immediately (async). A subsequent 100 / 7 returns 14 r2 with normal latency and no residue from the aborted op.
